lfsr_note_gen: RTL and testbench

Parametrised Galois LFSR random source with seed load, free-running step and lockup-proof reset. Adds a lane-draw engine that turns LFSR output into a note-lane index in 0..LANES-1. The draw engine uses rejection sampling, can optionally forbid repeating the previous lane, and has a bounded-retry fallback. It sits between the game sequencer, which requests lanes, and the note spawner, which consumes them.

---
 rtl/lfsr_note_gen.sv | 140 ++++++++++++++
 tb/tb_lfsr_note_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_note_gen.sv
// lfsr_note_gen
//   Galois LFSR random source with seed load, free-running step and a
//   lockup guard. A lane-draw engine turns LFSR output into a note-lane
//   index in 0..LANES-1. It uses rejection sampling, can optionally forbid
//   repeating the last issued lane, and falls back to a deterministic lane
//   once a draw has used up its retries.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   seed       seed value, used when load_seed is high
//   load_seed  loads seed (zero maps to SEED_DEFAULT), aborts any draw
//   step_en    advance the LFSR one step this edge
//   lane_req   request a lane draw (sampled only while idle)
//   rand_out   current LFSR state
//   lane_out   last issued lane index
//   lane_valid one-cycle pulse, lane_out is new
//   busy       high while a draw is in progress
module lfsr_note_gen #(
  parameter int unsigned       WIDTH        = 16,
  parameter logic [WIDTH-1:0]  TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED_DEFAULT = 16'hACE1,
  parameter int unsigned       LANES        = 4,
  parameter int unsigned       LANE_W       = 2,
  parameter bit                NO_REPEAT    = 1'b1,
  parameter int unsigned       MAX_TRIES    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  seed,
  input  logic              load_seed,
  input  logic              step_en,
  input  logic              lane_req,
  output logic [WIDTH-1:0]  rand_out,
  output logic [LANE_W-1:0] lane_out,
  output logic              lane_valid,
  output logic              busy
);

  localparam int unsigned TW = $clog2(MAX_TRIES) + 1;

  typedef enum logic {
    IDLE,
    DRAW
  } state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    lfsr_q;
  logic [WIDTH-1:0]    lfsr_d;
  logic [LANE_W-1:0]   lane_q;
  logic                valid_q;
  logic                have_last_q;
  logic [TW-1:0]       tries_q;

  logic [LANE_W-1:0]   cand;
  logic                accept;
  logic                last_try;
  logic [LANE_W-1:0]   fallback_lane;

  // One Galois step; an all-zero result would lock the register, so
  // substitute the default seed.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ TAPS;
    end
    if (lfsr_d == '0) begin
      lfsr_d = SEED_DEFAULT;
    end
  end

  // Candidate is taken from the pre-step state of the current edge.
  always_comb begin
    cand     = lfsr_q[LANE_W-1:0];
    accept   = ({1'b0, cand} < (LANE_W+1)'(LANES)) &&
               !(NO_REPEAT && have_last_q && (cand == lane_q));
    last_try = (tries_q == TW'(MAX_TRIES - 1));
    // Wrap at LANES rather than at 2^LANE_W.
    if (!have_last_q) begin
      fallback_lane = '0;
    end else if (lane_q == LANE_W'(LANES - 1)) begin
      fallback_lane = '0;
    end else begin
      fallback_lane = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_DEFAULT;
      lane_q      <= '0;
      valid_q     <= 1'b0;
      have_last_q <= 1'b0;
      tries_q     <= '0;
    end else if (load_seed) begin
      lfsr_q      <= (seed == '0) ? SEED_DEFAULT : seed;
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      have_last_q <= 1'b0;
      tries_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      // Drawing consumes one step per cycle; step_en on top still gives one.
      if (step_en || (state_q == DRAW)) begin
        lfsr_q <= lfsr_d;
      end
      case (state_q)
        IDLE: begin
          if (lane_req) begin
            state_q <= DRAW;
            tries_q <= '0;
          end
        end
        DRAW: begin
          if (accept) begin
            lane_q      <= cand;
            valid_q     <= 1'b1;
            have_last_q <= 1'b1;
            state_q     <= IDLE;
          end else if (last_try) begin
            lane_q      <= fallback_lane;
            valid_q     <= 1'b1;
            have_last_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            tries_q <= tries_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rand_out   = lfsr_q;
  assign lane_out   = lane_q;
  assign lane_valid = valid_q;
  assign busy       = (state_q == DRAW);

endmodule

// File: tb/tb_lfsr_note_gen.sv
// Bench for lfsr_note_gen. Three instances share one stimulus stream:
//   0: defaults (LANES=4, MAX_TRIES=8)
//   1: LANES=3
//   2: MAX_TRIES=1
// A per-instance model predicts every output each cycle; each draw is
// resolved in one go when it starts (number of DRAW cycles and the lane),
// then played out. Directed literal checks pin the model to hand values.
module tb_lfsr_note_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] seed = '0;
  logic        load_seed = 1'b0;
  logic        step_en = 1'b0;
  logic        lane_req = 1'b0;

  logic [15:0] ro0, ro1, ro2;
  logic [1:0]  lo0, lo1, lo2;
  logic        lv0, lv1, lv2;
  logic        bz0, bz1, bz2;

  int total = 0;
  int bad   = 0;
  bit en    = 1'b0;

  always #5 clk = ~clk;

  lfsr_note_gen u_a (
    .clk(clk), .rst(rst), .seed(seed), .load_seed(load_seed),
    .step_en(step_en), .lane_req(lane_req), .rand_out(ro0),
    .lane_out(lo0), .lane_valid(lv0), .busy(bz0)
  );

  lfsr_note_gen #(.LANES(3)) u_b (
    .clk(clk), .rst(rst), .seed(seed), .load_seed(load_seed),
    .step_en(step_en), .lane_req(lane_req), .rand_out(ro1),
    .lane_out(lo1), .lane_valid(lv1), .busy(bz1)
  );

  lfsr_note_gen #(.MAX_TRIES(1)) u_c (
    .clk(clk), .rst(rst), .seed(seed), .load_seed(load_seed),
    .step_en(step_en), .lane_req(lane_req), .rand_out(ro2),
    .lane_out(lo2), .lane_valid(lv2), .busy(bz2)
  );

  // ---------------- model ----------------
  int          LN[3] = '{4, 3, 4};
  int          MT[3] = '{8, 8, 1};
  logic [15:0] m_st[3];
  int          m_lane[3];
  bit          m_have[3];
  bit          m_valid[3];
  int          m_rem[3];
  int          m_pend[3];

  function automatic logic [15:0] nxt(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    if (n == 16'h0000) n = 16'hACE1;
    return n;
  endfunction

  // Resolve a whole draw from its starting state.
  task automatic resolve(input int i);
    logic [15:0] s;
    int c;
    bit found;
    s = m_st[i];
    found = 1'b0;
    for (int t = 0; t < MT[i] && !found; t++) begin
      c = int'(s % 16'd4);
      if (c < LN[i] && !(m_have[i] && c == m_lane[i])) begin
        found     = 1'b1;
        m_rem[i]  = t + 1;
        m_pend[i] = c;
      end else begin
        s = nxt(s);
      end
    end
    if (!found) begin
      m_rem[i]  = MT[i];
      m_pend[i] = m_have[i] ? (m_lane[i] + 1) % LN[i] : 0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_st[i] = 16'hACE1; m_lane[i] = 0; m_have[i] = 1'b0;
        m_valid[i] = 1'b0; m_rem[i] = 0; m_pend[i] = 0;
      end else if (load_seed) begin
        m_st[i] = (seed == 16'h0000) ? 16'hACE1 : seed;
        m_rem[i] = 0; m_have[i] = 1'b0; m_valid[i] = 1'b0;
      end else begin
        m_valid[i] = 1'b0;
        if (m_rem[i] > 0) begin
          m_st[i] = nxt(m_st[i]);
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_lane[i] = m_pend[i]; m_have[i] = 1'b1; m_valid[i] = 1'b1;
          end
        end else if (lane_req) begin
          if (step_en) m_st[i] = nxt(m_st[i]);
          resolve(i);
        end else if (step_en) begin
          m_st[i] = nxt(m_st[i]);
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic [15:0] r, input logic [1:0] l,
                     input logic v, input logic b);
    chk("rand", i, 32'(r), 32'(m_st[i]));
    chk("lane", i, 32'(l), 32'(m_lane[i]));
    chk("valid", i, 32'(v), 32'(m_valid[i]));
    chk("busy", i, 32'(b), 32'(m_rem[i] > 0));
  endtask

  always @(negedge clk) begin
    if (en) begin
      cmp(0, ro0, lo0, lv0, bz0);
      cmp(1, ro1, lo1, lv1, bz1);
      cmp(2, ro2, lo2, lv2, bz2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit ld, input logic [15:0] sd, input bit st, input bit rq);
    @(negedge clk);
    load_seed = ld; seed = sd; step_en = st; lane_req = rq;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] seq_exp[4] = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680};
  int vcnt;

  initial begin
    #12 rst = 1'b1;
    #1 en = 1'b1;

    // zero seed maps to default
    cyc(1, 16'h0000, 0, 0); settle();
    chk("zseed", 0, 32'(ro0), 32'hACE1);

    // plain stepping
    cyc(1, 16'h0001, 0, 0); settle();
    chk("load1", 0, 32'(ro0), 32'h0001);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 16'h0000, 1, 0); settle();
      chk("step", k, 32'(ro0), 32'(seq_exp[k]));
    end

    // basic draw
    cyc(1, 16'h0001, 0, 0);
    cyc(0, 16'h0000, 0, 1); settle();
    chk("d1busy", 0, 32'(bz0), 32'd1);
    chk("d1nov", 0, 32'(lv0), 32'd0);
    cyc(0, 16'h0000, 0, 0); settle();
    chk("d1valid", 0, 32'(lv0), 32'd1);
    chk("d1lane", 0, 32'(lo0), 32'd1);
    chk("d1rand", 0, 32'(ro0), 32'hB400);
    cyc(0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 0); settle();
    chk("d2lane", 0, 32'(lo0), 32'd0);
    chk("d2rand", 0, 32'(ro0), 32'h5A00);

    // rejection with LANES=3
    cyc(1, 16'h0003, 0, 0);
    cyc(0, 16'h0000, 0, 1); settle();
    chk("rjbusy1", 1, 32'(bz1), 32'd1);
    cyc(0, 16'h0000, 0, 0); settle();
    chk("rjbusy2", 1, 32'(bz1), 32'd1);
    chk("rjnov", 1, 32'(lv1), 32'd0);
    chk("rjrand", 1, 32'(ro1), 32'hB401);
    cyc(0, 16'h0000, 0, 0); settle();
    chk("rjvalid", 1, 32'(lv1), 32'd1);
    chk("rjlane", 1, 32'(lo1), 32'd1);
    chk("rjidle", 1, 32'(bz1), 32'd0);
    chk("rjlaneA", 0, 32'(lo0), 32'd3);

    // no-repeat and fallback
    cyc(1, 16'h0010, 0, 0);
    cyc(0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 0); settle();
    chk("nr1lane", 0, 32'(lo0), 32'd0);
    chk("nr1rand", 0, 32'(ro0), 32'h0008);
    cyc(0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 0); settle();
    chk("fbvalid", 2, 32'(lv2), 32'd1);
    chk("fblane", 2, 32'(lo2), 32'd1);
    chk("nrbusy", 0, 32'(bz0), 32'd1);
    chk("nrrand1", 0, 32'(ro0), 32'h0004);
    cyc(0, 16'h0000, 0, 0); settle();
    chk("nrrand2", 0, 32'(ro0), 32'h0002);
    cyc(0, 16'h0000, 0, 0); settle();
    chk("nr2valid", 0, 32'(lv0), 32'd1);
    chk("nr2lane", 0, 32'(lo0), 32'd2);
    chk("nr2rand", 0, 32'(ro0), 32'h0001);

    // abort a draw with load_seed
    cyc(1, 16'h0010, 0, 0);
    cyc(0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 0);
    cyc(0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 0);
    cyc(1, 16'h0010, 0, 0); settle();
    chk("abbusy", 0, 32'(bz0), 32'd0);
    chk("abnov", 0, 32'(lv0), 32'd0);
    chk("abrand", 0, 32'(ro0), 32'h0010);
    cyc(0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 0); settle();
    chk("abhave", 0, 32'(lo0), 32'd0);
    chk("abhavev", 0, 32'(lv0), 32'd1);

    // lane_req held: one pulse per completed draw
    cyc(1, 16'h0010, 0, 0);
    vcnt = 0;
    for (int e = 0; e < 8; e++) begin
      cyc(0, 16'h0000, 0, 1); settle();
      if (lv0) vcnt++;
    end
    cyc(0, 16'h0000, 0, 0);
    chk("holdcnt", 0, 32'(vcnt), 32'd3);
    chk("holdlane", 0, 32'(lo0), 32'd1);
    chk("holdrand", 0, 32'(ro0), 32'hB400);

    // asynchronous reset in the middle of a draw
    cyc(1, 16'h0003, 0, 0);
    cyc(0, 16'h0000, 1, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstrand", 1, 32'(ro1), 32'hACE1);
    chk("rstvalid", 1, 32'(lv1), 32'd0);
    chk("rstbusy", 1, 32'(bz1), 32'd0);
    chk("rstlane", 0, 32'(lo0), 32'd0);
    @(negedge clk);
    load_seed = 1'b0; step_en = 1'b0; lane_req = 1'b0;
    rst = 1'b1;
    cyc(0, 16'h0000, 1, 0);
    cyc(0, 16'h0000, 0, 0);
    cyc(0, 16'h0000, 0, 0);
    @(negedge clk);
    #1 en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
